// File: rtl/ifetch_queue_pkg.sv
// Shared types and constants for the instruction prefetch queue.
package ifetch_queue_pkg;

  localparam int WORD_W      = 32;
  localparam int INSTR_BYTES = 4;

  typedef enum logic [1:0] {
    BOOT,
    FETCH,
    WAIT,
    DRAIN
  } fetch_state_t;

  // Forces a byte address onto an instruction-word boundary.
  function automatic logic [WORD_W-1:0] word_align(input logic [WORD_W-1:0] addr);
    return addr & ~(WORD_W'(INSTR_BYTES - 1));
  endfunction

endpackage

// File: rtl/ifq_buf.sv
// Circular buffer of fetched instructions with their addresses.
// One write port at the tail, two read ports at head and head+1.
module ifq_buf
  import ifetch_queue_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int PTR_W = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              push,
  input  logic              flush,
  input  logic [1:0]        take,
  input  logic [WORD_W-1:0] push_instr,
  input  logic [WORD_W-1:0] push_addr,
  output logic [WORD_W-1:0] instr1,
  output logic [WORD_W-1:0] instr2,
  output logic [WORD_W-1:0] addr1,
  output logic [WORD_W-1:0] addr2,
  output logic              valid1,
  output logic              valid2,
  output logic [PTR_W:0]    count_next
);

  logic [PTR_W-1:0]  head;
  logic [PTR_W-1:0]  tail;
  logic [PTR_W-1:0]  head_p1;
  logic [PTR_W:0]    count;
  logic [PTR_W:0]    pops;
  logic [WORD_W-1:0] instr_mem [DEPTH];
  logic [WORD_W-1:0] addr_mem  [DEPTH];

  // Pop count is the request clamped to what is stored; a flush cancels it.
  always_comb begin
    pops = '0;
    if (!flush) begin
      if (take >= 2'd2 && count >= (PTR_W+1)'(2)) begin
        pops = (PTR_W+1)'(2);
      end else if (take != 2'd0 && count != '0) begin
        pops = (PTR_W+1)'(1);
      end
    end
    count_next = flush ? '0 : count + (PTR_W+1)'(push) - pops;
  end

  // Pointer and occupancy registers; pointers wrap naturally at DEPTH.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else if (flush) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      head  <= head + pops[PTR_W-1:0];
      tail  <= tail + PTR_W'(push);
      count <= count_next;
    end
  end

  // Entry storage needs no reset: entries are only visible when counted.
  always_ff @(posedge clk) begin
    if (push) begin
      instr_mem[tail] <= push_instr;
      addr_mem[tail]  <= push_addr;
    end
  end

  // Read ports at head and head+1, zeroed when the entry is empty.
  always_comb begin
    head_p1 = head + PTR_W'(1);
    valid1  = (count != '0);
    valid2  = (count > (PTR_W+1)'(1));
    instr1  = valid1 ? instr_mem[head]   : '0;
    addr1   = valid1 ? addr_mem[head]    : '0;
    instr2  = valid2 ? instr_mem[head_p1] : '0;
    addr2   = valid2 ? addr_mem[head_p1]  : '0;
  end

endmodule

// File: rtl/ifetch_queue.sv
// Prefetch queue: fetches words over req/ack, buffers them, and presents
// up to two in-order instructions per cycle; redirects flush and refetch.
module ifetch_queue
  import ifetch_queue_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int PTR_W = 3
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic [WORD_W-1:0] PC_init,
  input  logic              redirect,
  input  logic [WORD_W-1:0] redirect_addr,
  output logic              imem_req,
  output logic [WORD_W-1:0] imem_addr,
  input  logic              imem_ack,
  input  logic [WORD_W-1:0] imem_rdata,
  input  logic [1:0]        take,
  output logic [WORD_W-1:0] Instr1_out,
  output logic [WORD_W-1:0] Instr2_out,
  output logic [WORD_W-1:0] addr1_out,
  output logic [WORD_W-1:0] addr2_out,
  output logic              valid1,
  output logic              valid2
);

  fetch_state_t      state;
  fetch_state_t      state_next;
  logic [WORD_W-1:0] fetch_pc;
  logic [WORD_W-1:0] fetch_pc_next;
  logic [WORD_W-1:0] pend_addr;
  logic [WORD_W-1:0] pend_next;
  logic              req_next;
  logic              push;
  logic              flush;
  logic [PTR_W:0]    count_next;

  // fetch_pc is held while a request is outstanding, so it is the address.
  assign imem_addr = fetch_pc;

  ifq_buf #(
    .DEPTH(DEPTH),
    .PTR_W(PTR_W)
  ) u_buf (
    .clk       (CLK),
    .rst_n     (RESET),
    .push      (push),
    .flush     (flush),
    .take      (take),
    .push_instr(imem_rdata),
    .push_addr (fetch_pc),
    .instr1    (Instr1_out),
    .instr2    (Instr2_out),
    .addr1     (addr1_out),
    .addr2     (addr2_out),
    .valid1    (valid1),
    .valid2    (valid2),
    .count_next(count_next)
  );

  // State, fetch address, pending redirect target and request flag.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state     <= BOOT;
      fetch_pc  <= '0;
      pend_addr <= '0;
      imem_req  <= 1'b0;
    end else begin
      state     <= state_next;
      fetch_pc  <= fetch_pc_next;
      pend_addr <= pend_next;
      imem_req  <= req_next;
    end
  end

  // Fetch sequencing: redirect outranks everything except boot; a request
  // is only launched when the queue will have room for its word.
  always_comb begin
    state_next    = state;
    fetch_pc_next = fetch_pc;
    pend_next     = pend_addr;
    push          = 1'b0;
    flush         = 1'b0;
    case (state)
      BOOT: begin
        fetch_pc_next = word_align(PC_init);
        state_next    = FETCH;
      end
      FETCH: begin
        if (redirect) begin
          flush         = 1'b1;
          fetch_pc_next = word_align(redirect_addr);
          state_next    = WAIT;
        end else if (count_next < (PTR_W+1)'(DEPTH)) begin
          state_next = WAIT;
        end
      end
      WAIT: begin
        if (redirect) begin
          flush = 1'b1;
          if (imem_ack) begin
            fetch_pc_next = word_align(redirect_addr);
          end else begin
            pend_next  = word_align(redirect_addr);
            state_next = DRAIN;
          end
        end else if (imem_ack) begin
          push          = 1'b1;
          fetch_pc_next = fetch_pc + WORD_W'(INSTR_BYTES);
          state_next    = (count_next < (PTR_W+1)'(DEPTH)) ? WAIT : FETCH;
        end
      end
      DRAIN: begin
        if (redirect) begin
          flush     = 1'b1;
          pend_next = word_align(redirect_addr);
        end
        if (imem_ack) begin
          fetch_pc_next = redirect ? word_align(redirect_addr) : pend_addr;
          state_next    = WAIT;
        end
      end
      default: state_next = BOOT;
    endcase
    req_next = (state_next == WAIT) || (state_next == DRAIN);
  end

endmodule
